// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns and a
// counter-width helper.
package ssd_pkg;

   // Segment bit order is {g,f,e,d,c,b,a}. A 0 lights the segment (common anode).
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_A   = 7'b0001000;
   localparam logic [6:0] SEG_B   = 7'b0000011;
   localparam logic [6:0] SEG_C   = 7'b1000110;
   localparam logic [6:0] SEG_D   = 7'b0100001;
   localparam logic [6:0] SEG_E   = 7'b0000110;
   localparam logic [6:0] SEG_F   = 7'b0001110;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module ssd_hex_decode
   import ssd_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_OFF;
      case (i_nib)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/ssd_scan_mux.sv
// Multiplexed N-digit common-anode display driver with double-buffered frames.
// Define SSD_LEADING_ZERO_BLANK_EN to darken leading zero digits.
module ssd_scan_mux
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank,
   output logic [6:0]              ssd,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   sel
);

   localparam int IDX_W = cnt_w(NUM_DIGITS);
   localparam int PRE_W = cnt_w(REFRESH_DIV);

   logic [PRE_W-1:0]        r_presc;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_pend_bcd;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic                    r_pend_vld;
   logic [4*NUM_DIGITS-1:0] r_act_bcd;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [6:0]              r_ssd;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_sel;

   logic                    w_tc;
   logic                    w_last_digit;
   logic                    w_frame_end;
   logic [3:0]              w_nib;
   logic                    w_dp_bit;
   logic [NUM_DIGITS-1:0]   w_sel_dec;
   logic                    w_lz_blank;
   logic [6:0]              w_seg;

   assign w_tc         = (r_presc == PRE_W'(REFRESH_DIV - 1));
   assign w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));
   assign w_frame_end  = w_tc & w_last_digit;

   // Digit mux and one-cold select share the same index compare.
   always_comb begin
      w_nib     = 4'h0;
      w_dp_bit  = 1'b0;
      w_sel_dec = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib        = r_act_bcd[4*i +: 4];
            w_dp_bit     = r_act_dp[i];
            w_sel_dec[i] = 1'b0;
         end
      end
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   // Walk down from the top digit; the run of zeros stops at the first nonzero.
   always_comb begin
      logic zero_run;
      zero_run   = 1'b1;
      w_lz_blank = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run = zero_run & (r_act_bcd[4*i +: 4] == 4'h0);
         if (zero_run && (r_idx == IDX_W'(i))) w_lz_blank = 1'b1;
      end
   end
`else
   assign w_lz_blank = 1'b0;
`endif

   ssd_hex_decode u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (w_tc) begin
         r_presc <= '0;
         r_idx   <= w_last_digit ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_presc <= r_presc + PRE_W'(1);
      end
   end

   // Transfer reads the old pending value; a coincident load still lands and re-arms the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_bcd <= '0;
         r_pend_dp  <= '0;
         r_pend_vld <= 1'b0;
         r_act_bcd  <= '0;
         r_act_dp   <= '0;
      end else begin
         if (w_frame_end && r_pend_vld) begin
            r_act_bcd  <= r_pend_bcd;
            r_act_dp   <= r_pend_dp;
            r_pend_vld <= 1'b0;
         end
         if (load) begin
            r_pend_bcd <= bcd_in;
            r_pend_dp  <= dp_in;
            r_pend_vld <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel <= '1;
         r_ssd <= SEG_OFF;
         r_dp  <= 1'b1;
      end else if (blank) begin
         r_sel <= '1;
         r_ssd <= SEG_OFF;
         r_dp  <= 1'b1;
      end else begin
         r_sel <= w_sel_dec;
         r_ssd <= w_lz_blank ? SEG_OFF : w_seg;
         r_dp  <= ~w_dp_bit;
      end
   end

   assign ssd = r_ssd;
   assign dp  = r_dp;
   assign sel = r_sel;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: reference model feeds an expected queue, plus directed checks.
module tb_ssd_scan_mux;

   localparam int N = 4;
   localparam int R = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [4*N-1:0] bcd_in = '0;
   logic [N-1:0]   dp_in = '0;
   logic           load = 1'b0;
   logic           blank = 1'b0;
   logic [6:0]     ssd;
   logic           dp;
   logic [N-1:0]   sel;

   int n_cmp = 0;
   int n_bad = 0;

   logic [N+7:0] exp_q[$];

   // Decode table taken directly from the segment list.
   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic [3:0] t2_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] t2_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

   int             m_pre = 0;
   int             m_idx = 0;
   logic [4*N-1:0] m_pend_bcd = '0;
   logic [N-1:0]   m_pend_dp = '0;
   logic           m_flag = 1'b0;
   logic [4*N-1:0] m_act_bcd = '0;
   logic [N-1:0]   m_act_dp = '0;

   ssd_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bcd_in (bcd_in),
      .dp_in  (dp_in),
      .load   (load),
      .blank  (blank),
      .ssd    (ssd),
      .dp     (dp),
      .sel    (sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N+7:0] got, input logic [N+7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s t=%0t got sel/ssd/dp=%b exp=%b", tag, $time, got, exp);
      end
   endtask

   // Reference model: predicts the registered outputs produced by each clock edge.
   always @(posedge clk or negedge rst_n) begin : model
      logic [3:0] nib;
      logic [6:0] seg;
      if (!rst_n) begin
         m_pre      <= 0;
         m_idx      <= 0;
         m_pend_bcd <= '0;
         m_pend_dp  <= '0;
         m_flag     <= 1'b0;
         m_act_bcd  <= '0;
         m_act_dp   <= '0;
         exp_q.delete();
      end else begin
         nib = m_act_bcd[4*m_idx +: 4];
         seg = seg_tab[nib];
`ifdef SSD_LEADING_ZERO_BLANK_EN
         if (m_idx > 0 && (m_act_bcd >> (4*m_idx)) == '0) seg = 7'h7F;
`endif
         if (blank) exp_q.push_back({{N{1'b1}}, 7'h7F, 1'b1});
         else       exp_q.push_back({~(N'(1) << m_idx), seg, ~m_act_dp[m_idx]});
         if (m_pre == R-1 && m_idx == N-1 && m_flag) begin
            m_act_bcd <= m_pend_bcd;
            m_act_dp  <= m_pend_dp;
            m_flag    <= 1'b0;
         end
         if (load) begin
            m_pend_bcd <= bcd_in;
            m_pend_dp  <= dp_in;
            m_flag     <= 1'b1;
         end
         m_pre <= (m_pre == R-1) ? 0 : m_pre + 1;
         if (m_pre == R-1) m_idx <= (m_idx == N-1) ? 0 : m_idx + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) chk("reset_hold", {sel, ssd, dp}, {{N{1'b1}}, 7'h7F, 1'b1});
      else if (exp_q.size() > 0) chk("scoreboard", {sel, ssd, dp}, exp_q.pop_front());
   end

   task automatic pulse_load(input logic [4*N-1:0] v, input logic [N-1:0] d);
      bcd_in = v;
      dp_in  = d;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
   endtask

   // Returns at the negedge where the model sits at (idx, pre).
   task automatic wait_pos(input int idx, input int pre);
      int k;
      k = 0;
      while (!(m_idx == idx && m_pre == pre) && k < 64) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      assert (k < 64) else begin
         n_bad++;
         $error("FAIL wait_pos timeout got=%0d exp<64", k);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_after_reset", {sel, ssd, dp}, {4'b1110, 7'b1000000, 1'b1});

      // Frame 1234 with dp on digit 2, shown from the next boundary.
      pulse_load(16'h1234, 4'b0100);
      wait_pos(N-1, R-1);
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < R; c++) begin
            @(negedge clk);
            chk("frame_1234", {sel, ssd, dp}, {t2_sel[d], t2_seg[d], (d == 2) ? 1'b0 : 1'b1});
         end
      end

      // Asynchronous reset mid-scan.
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {sel, ssd, dp}, {4'b1111, 7'b1111111, 1'b1});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_digit0", {sel, ssd, dp}, {4'b1110, 7'b1000000, 1'b1});

      pulse_load(16'hABCD, 4'b0000);
      wait_pos(N-1, R-1);
      repeat (2*N*R) @(negedge clk);
      pulse_load(16'hEF00, 4'b1001);
      wait_pos(N-1, R-1);
      repeat (2*N*R) @(negedge clk);

      // Load while scanning digit 2: current frame must finish unchanged.
      pulse_load(16'h1234, 4'b0000);
      wait_pos(N-1, R-1);
      @(negedge clk);
      wait_pos(2, 0);
      pulse_load(16'h5678, 4'b0010);
      repeat (2*N*R) @(negedge clk);

      // Load landing on the frame-boundary cycle.
      wait_pos(0, 1);
      pulse_load(16'h1111, 4'b0000);
      wait_pos(N-1, R-1);
      pulse_load(16'h2222, 4'b1111);
      repeat (3*N*R) @(negedge clk);

      blank = 1'b1;
      repeat (20) @(negedge clk);
      blank = 1'b0;
      repeat (2*N*R) @(negedge clk);

      pulse_load(16'h0042, 4'b0100);
      repeat (3*N*R) @(negedge clk);
      pulse_load(16'h0000, 4'b0000);
      repeat (3*N*R) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
